// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family (serializer and deserializer).
// Bit-order constants are common to both ends so a matched pair agrees on ordering.
package shift_pkg;

  localparam int SHIFT_WIDTH_DEFAULT = 8;

  localparam bit BIT_ORDER_MSB = 1'b1;
  localparam bit BIT_ORDER_LSB = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } shift_state_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle; master is the deserializer, slave is the
// bit source plus word consumer.
interface sipo_deserializer_if
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEFAULT
);

  logic             ser_in;
  logic             ser_valid;
  logic             ser_sync;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;
  logic             overrun;
  logic             clr_overrun;
  logic             sync_err;
  logic             busy;

  modport master (
    input  ser_in, ser_valid, ser_sync, par_ready, clr_overrun,
    output par_out, par_valid, overrun, sync_err, busy
  );

  modport slave (
    output ser_in, ser_valid, ser_sync, par_ready, clr_overrun,
    input  par_out, par_valid, overrun, sync_err, busy
  );

endinterface

// File: rtl/word_hold_reg.sv
// One-deep valid/ready word holder; a load arriving while full and not draining
// is dropped and sets the sticky overrun flag (set beats clear).
module word_hold_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             drain,
  input  logic             clr_overrun,
  output logic             full,
  output logic [WIDTH-1:0] dat,
  output logic             overrun
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             overrun_q, overrun_d;
  logic             take, accept, drop;

  always_comb begin
    // drain only means something while a word is actually held
    take      = drain & full_q;
    accept    = load & (~full_q | take);
    drop      = load & full_q & ~take;
    full_d    = accept | (full_q & ~take);
    dat_d     = accept ? load_dat : dat_q;
    overrun_d = drop | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 1'b0;
      dat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      dat_q     <= dat_d;
      overrun_q <= overrun_d;
    end
  end

  assign full    = full_q;
  assign dat     = dat_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Rebuilds WIDTH-bit words from a qualified bit stream; word is valid the cycle
// after its last bit. Backpressure: one held word, further completions are dropped.
module sipo_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = SHIFT_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic                clk,
  input  logic                reset,
  sipo_deserializer_if.master bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic             sync_err_q, sync_err_d;
  logic             word_done;
  shift_state_t     state;

  always_comb begin
    state      = (cnt_q == '0) ? IDLE : RECV;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    word_done  = 1'b0;
    shifted    = sr_q;
    cnt_base   = cnt_q;
    if (bus.ser_valid) begin
      if (bus.ser_sync) begin
        // restart the word with this bit as bit 0, discarding any partial word
        cnt_base   = '0;
        sync_err_d = (state == RECV);
        shifted    = (MSB_FIRST == BIT_ORDER_MSB) ? {{(WIDTH-1){1'b0}}, bus.ser_in}
                                                  : {bus.ser_in, {(WIDTH-1){1'b0}}};
      end else begin
        shifted    = (MSB_FIRST == BIT_ORDER_MSB) ? {sr_q[WIDTH-2:0], bus.ser_in}
                                                  : {bus.ser_in, sr_q[WIDTH-1:1]};
      end
      sr_d = shifted;
      if (cnt_base == CNT_LAST) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d     = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  word_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load        (word_done),
    .load_dat    (sr_d),
    .drain       (bus.par_ready),
    .clr_overrun (bus.clr_overrun),
    .full        (bus.par_valid),
    .dat         (bus.par_out),
    .overrun     (bus.overrun)
  );

  assign bus.sync_err = sync_err_q;
  assign bus.busy     = (state == RECV);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Drives an MSB-first and an LSB-first deserializer with the same bit stream and
// checks both against a bit-list model every cycle, plus literal word checks.
module tb_sipo_deserializer;
  import shift_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_in = 1'b0, ser_valid = 1'b0, ser_sync = 1'b0;
  logic par_ready = 1'b1, clr_overrun = 1'b0;

  sipo_deserializer_if #(.WIDTH(W)) bus_m ();
  sipo_deserializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.ser_in      = ser_in;
  assign bus_m.ser_valid   = ser_valid;
  assign bus_m.ser_sync    = ser_sync;
  assign bus_m.par_ready   = par_ready;
  assign bus_m.clr_overrun = clr_overrun;
  assign bus_l.ser_in      = ser_in;
  assign bus_l.ser_valid   = ser_valid;
  assign bus_l.ser_sync    = ser_sync;
  assign bus_l.par_ready   = par_ready;
  assign bus_l.clr_overrun = clr_overrun;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(BIT_ORDER_MSB)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(BIT_ORDER_LSB)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = MSB-first instance, index 1 = LSB-first instance.
  bit         started = 1'b0;
  int         m_cnt [2];
  bit         m_bits[2][W];
  logic [W-1:0] m_dat [2];
  bit         m_vld [2];
  bit         m_ovr [2];
  bit         m_serr[2];
  bit         md_done, md_drain, md_serr;
  logic [W-1:0] md_word;

  function automatic logic [W-1:0] build(input int d);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (d == 0) w[W-1-i] = m_bits[d][i];
      else        w[i]     = m_bits[d][i];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_cnt[d]  = 0;
        m_vld[d]  = 1'b0;
        m_dat[d]  = '0;
        m_ovr[d]  = 1'b0;
        m_serr[d] = 1'b0;
      end else begin
        md_done  = 1'b0;
        md_serr  = 1'b0;
        md_word  = '0;
        md_drain = m_vld[d] && par_ready;
        if (ser_valid) begin
          if (ser_sync) begin
            md_serr  = (m_cnt[d] != 0);
            m_cnt[d] = 0;
          end
          m_bits[d][m_cnt[d]] = ser_in;
          m_cnt[d]++;
          if (m_cnt[d] == W) begin
            md_done  = 1'b1;
            md_word  = build(d);
            m_cnt[d] = 0;
          end
        end
        if (md_done && m_vld[d] && !md_drain) begin
          m_ovr[d] = 1'b1;
        end else begin
          if (clr_overrun) m_ovr[d] = 1'b0;
          if (md_done) begin
            m_dat[d] = md_word;
            m_vld[d] = 1'b1;
          end else if (md_drain) begin
            m_vld[d] = 1'b0;
          end
        end
        m_serr[d] = md_serr;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("msb.par_valid", bus_m.par_valid, m_vld[0]);
      check("msb.par_out",   bus_m.par_out,   m_dat[0]);
      check("msb.overrun",   bus_m.overrun,   m_ovr[0]);
      check("msb.sync_err",  bus_m.sync_err,  m_serr[0]);
      check("msb.busy",      bus_m.busy,      m_cnt[0] != 0);
      check("lsb.par_valid", bus_l.par_valid, m_vld[1]);
      check("lsb.par_out",   bus_l.par_out,   m_dat[1]);
      check("lsb.overrun",   bus_l.overrun,   m_ovr[1]);
      check("lsb.sync_err",  bus_l.sync_err,  m_serr[1]);
      check("lsb.busy",      bus_l.busy,      m_cnt[1] != 0);
    end
  end

  // Present inputs, let one rising edge sample them, return just after it.
  task automatic step(input logic v, input logic b, input logic s);
    ser_valid = v;
    ser_in    = b;
    ser_sync  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], 1'b0);
    ser_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst.par_valid", bus_m.par_valid, 1'b0);
    check("rst.par_out",   bus_m.par_out,   8'h00);
    check("rst.overrun",   bus_m.overrun,   1'b0);
    check("rst.busy",      bus_m.busy,      1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Bits 1,1,0,1,0,0,0,0 back to back
    send_word(8'hD0);
    check("b2b.msb_valid", bus_m.par_valid, 1'b1);
    check("b2b.msb_word",  bus_m.par_out,   8'hD0);
    check("b2b.lsb_word",  bus_l.par_out,   8'h0B);
    step(1'b0, 1'b0, 1'b0);
    check("b2b.valid_drop", bus_m.par_valid, 1'b0);

    // Same bits with a one-cycle gap between each
    w = 8'hD0;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0);
      if (i > 0) begin
        step(1'b0, 1'b0, 1'b0);
        check("gap.busy_msb", bus_m.busy, 1'b1);
        check("gap.busy_lsb", bus_l.busy, 1'b1);
      end
    end
    check("gap.lsb_valid", bus_l.par_valid, 1'b1);
    check("gap.lsb_word",  bus_l.par_out,   8'h0B);
    check("gap.msb_word",  bus_m.par_out,   8'hD0);
    step(1'b0, 1'b0, 1'b0);

    // Overrun with consumer stalled
    par_ready = 1'b0;
    send_word(8'h12);
    check("ovr.first_valid", bus_m.par_valid, 1'b1);
    check("ovr.first_word",  bus_m.par_out,   8'h12);
    send_word(8'h34);
    check("ovr.held_word", bus_m.par_out, 8'h12);
    check("ovr.flag",      bus_m.overrun, 1'b1);
    par_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("ovr.drain_valid", bus_m.par_valid, 1'b0);
    check("ovr.drain_hold",  bus_m.par_out,   8'h12);
    check("ovr.sticky",      bus_m.overrun,   1'b1);
    par_ready   = 1'b0;
    clr_overrun = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_overrun = 1'b0;
    check("ovr.cleared", bus_m.overrun, 1'b0);

    // Clear and a new overrun on the same edge
    send_word(8'h12);
    w = 8'h34;
    for (int i = W - 1; i >= 1; i--) step(1'b1, w[i], 1'b0);
    clr_overrun = 1'b1;
    step(1'b1, w[0], 1'b0);
    clr_overrun = 1'b0;
    ser_valid   = 1'b0;
    check("ovr.set_wins", bus_m.overrun, 1'b1);
    clr_overrun = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_overrun = 1'b0;
    check("ovr.cleared2", bus_m.overrun, 1'b0);
    check("ovr.still_12", bus_m.par_out, 8'h12);

    // Drain on the exact edge the next word completes
    for (int i = W - 1; i >= 1; i--) step(1'b1, w[i], 1'b0);
    par_ready = 1'b1;
    step(1'b1, w[0], 1'b0);
    ser_valid = 1'b0;
    check("drn.word",    bus_m.par_out,   8'h34);
    check("drn.valid",   bus_m.par_valid, 1'b1);
    check("drn.overrun", bus_m.overrun,   1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("drn.empty", bus_m.par_valid, 1'b0);

    // Resync mid-word: 3 stray bits, then sync + 7 bits of A7
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("sync.err_msb", bus_m.sync_err, 1'b1);
    check("sync.err_lsb", bus_l.sync_err, 1'b1);
    check("sync.busy",    bus_m.busy,     1'b1);
    w = 8'hA7;
    for (int i = W - 2; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0);
      if (i == W - 2) check("sync.err_pulse", bus_m.sync_err, 1'b0);
    end
    ser_valid = 1'b0;
    check("sync.msb_word", bus_m.par_out, 8'hA7);
    check("sync.lsb_word", bus_l.par_out, 8'hE5);

    // Reset mid-word, then a clean word
    par_ready = 1'b0;
    w = 8'h5C;
    for (int i = W - 1; i >= W - 5; i--) step(1'b1, w[i], 1'b0);
    ser_valid = 1'b0;
    check("mid.busy",  bus_m.busy,      1'b1);
    check("mid.valid", bus_m.par_valid, 1'b1);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("mrst.par_valid", bus_m.par_valid, 1'b0);
    check("mrst.par_out",   bus_m.par_out,   8'h00);
    check("mrst.overrun",   bus_m.overrun,   1'b0);
    check("mrst.sync_err",  bus_m.sync_err,  1'b0);
    check("mrst.busy",      bus_m.busy,      1'b0);
    check("mrst.lsb_busy",  bus_l.busy,      1'b0);
    reset     = 1'b0;
    par_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    send_word(8'h5C);
    check("post.valid",    bus_m.par_valid, 1'b1);
    check("post.msb_word", bus_m.par_out,   8'h5C);
    check("post.lsb_word", bus_l.par_out,   8'h3A);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver that rebuilds WIDTH-bit words from a qualified serial bit stream and presents each word on a parallel port with a valid/ready handshake. It is the receive end for the team's parallel-load shift registers when they are used as serializers. It has a one-word holding register, a sticky overrun flag and optional resynchronisation through a sync strobe.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 means the first received bit lands in par_out[WIDTH-1]; 0 means it lands in par_out[0].
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ser_in  in  1  serial data bit; sampled only when ser_valid=1.
- ser_valid  in  1  the ser_in bit is present this cycle.
- ser_sync  in  1  marks the current bit as bit 0 of a new word; ignored when ser_valid=0.
- par_out  out  WIDTH  assembled word; stable while par_valid=1.
- par_valid  out  1  par_out holds an unconsumed word.
- par_ready  in  1  consumer accepts the word; transfer occurs when par_valid and par_ready are both 1.
- overrun  out  1  sticky; a completed word was dropped because the holding register was full.
- clr_overrun  in  1  clears overrun.
- sync_err  out  1  one-cycle pulse; ser_sync arrived while a partial word was pending.
- busy  out  1  a partial word is in progress (bit count is not 0).

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0];
  - bit counter cnt, 0..WIDTH-1, width $clog2(WIDTH);
  - holding register, which drives par_out and par_valid.
- Two states, derived from cnt:
  - IDLE (cnt==0): IDLE -> RECV on an accepted bit when WIDTH>1.
  - RECV (cnt!=0): RECV -> IDLE when the word completes.
- Accepted bit (ser_valid=1):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: sr <= {ser_in, sr[WIDTH-1:1]}.
  - cnt increments.
- ser_valid=0: sr and cnt hold; gaps of any length are legal.
- Word completion:
  - Occurs on an accepted bit with cnt==WIDTH-1.
  - The completed word is the shifted sr including the current bit. cnt wraps to 0.
- Completion, holding register empty, or draining on the same edge (par_valid & par_ready): par_out <= completed word, and par_valid is 1 next cycle.
- Completion, holding register full and not draining:
  - The word is dropped and overrun <= 1.
  - par_out and par_valid are unchanged.
- Drain without completion: par_valid <= 0 and par_out holds its last value.
- ser_sync with ser_valid:
  - The bit is taken as bit 0: cnt <= 1, and sr is loaded with this bit only (all other positions 0).
  - If cnt!=0 beforehand, the partial word is discarded and sync_err pulses next cycle.
  - When WIDTH allows, the completion rule applies to the new count.
- clr_overrun and an overrun event on the same edge: set wins, and overrun=1.
- Reset, including mid-word: sr, cnt, par_out, par_valid, overrun, sync_err and busy all go to 0. Any partial word is lost.

## Timing
- Latency: par_valid rises on the edge that samples the last bit, so it is visible the cycle after that bit is presented.
- Throughput: one bit per cycle sustained. A new word can be accepted every WIDTH cycles with no bubbles when par_ready=1.
- Handshake:
  - par_out must not change while par_valid=1 and par_ready=0.
  - par_ready is ignored while par_valid=0.
- No combinational paths from inputs to outputs; every output is registered.

## Structure
- Shared package shift_pkg:
  - SHIFT_WIDTH_DEFAULT=8;
  - bit-order constants BIT_ORDER_MSB=1 and BIT_ORDER_LSB=0, also used by the matching serializer;
  - shift_state_t enum {IDLE, RECV}.
- One sub-module, word_hold_reg: a one-deep valid/ready holding register with load, drain and full outputs. It contains the overrun decision logic. The top level holds the shifter and the counter.

## Test plan
- MSB_FIRST=1, bits 1,1,0,1,0,0,0,0 on consecutive cycles, par_ready=1 -> par_valid=1 for one cycle after the 8th bit, par_out=8'hD0.
- MSB_FIRST=0, same bit sequence -> par_out=8'h0B. Repeat with ser_valid high every other cycle -> same word, busy held between bits.
- par_ready=0, send 8'h12 then 8'h34 -> par_out stays 8'h12 and overrun=1 the cycle after the 34's last bit. Raise par_ready -> par_valid drops. Pulse clr_overrun -> overrun=0. Clear and overrun on the same edge -> overrun stays 1.
- par_valid=1 holding 8'h12, par_ready=1 on the exact edge the next word 8'h34 completes -> par_out=8'h34, par_valid stays 1, overrun=0.
- 3 bits, then ser_sync with a bit, then 7 more bits forming 8'hA7 -> sync_err pulses once, and par_out=8'hA7.
- Reset asserted after 5 bits -> all outputs 0 the next cycle. The following 8 bits of 8'h5C decode to par_out=8'h5C.
